// File: rtl/flippy_pkg.sv
// Shared lane definitions for the flippy game: lane state encoding,
// target byte width and default descent row count.
package flippy_pkg;

  localparam int VALUE_W  = 8;
  localparam int ROWS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } lane_state_e;

  typedef struct packed {
    logic                 over;
    logic [VALUE_W-1:0]   val;
  } lane_evt_t;

endpackage

// File: rtl/flippy_match_filter.sv
// Switch/target comparator requiring MATCH_CYCLES consecutive
// equal samples while enabled before reporting a match.
module flippy_match_filter
  import flippy_pkg::*;
#(
  parameter int MATCH_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               en,
  input  logic [VALUE_W-1:0] switches,
  input  logic [VALUE_W-1:0] value,
  output logic               match
);

  localparam int CW = $clog2(MATCH_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(MATCH_CYCLES - 1);

  logic          eq;
  logic [CW-1:0] cnt_d, cnt_q;

  assign eq    = (switches == value);
  assign match = en && eq && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !en || !eq) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/flippy_lane.sv
// One falling-target lane. Define FLIPPY_LANE_MATCH_FILTER_EN to
// require MATCH_CYCLES consecutive matching samples before a hit.
module flippy_lane
  import flippy_pkg::*;
#(
  parameter int ROWS         = ROWS_DEF,
  parameter int MATCH_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    game_reset,
  input  logic                    tick,
  input  logic                    spawn,
  input  logic [VALUE_W-1:0]      spawn_value,
  input  logic [VALUE_W-1:0]      switches,
  output logic                    active,
  output logic [VALUE_W-1:0]      value,
  output logic [$clog2(ROWS)-1:0] height,
  output logic                    correct,
  output logic                    game_over
);

  localparam int HW = $clog2(ROWS);

  lane_state_e        state_d, state_q;
  logic [VALUE_W-1:0] value_d, value_q;
  logic [HW-1:0]      height_d, height_q;
  logic               match_w;
  logic               in_fall;

  assign in_fall = (state_q == FALL);

`ifdef FLIPPY_LANE_MATCH_FILTER_EN
  flippy_match_filter #(
    .MATCH_CYCLES (MATCH_CYCLES)
  ) u_filter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (game_reset),
    .en       (in_fall),
    .switches (switches),
    .value    (value_q),
    .match    (match_w)
  );
`else
  logic unused_mc;
  assign unused_mc = (MATCH_CYCLES != 0);
  assign match_w   = in_fall && (switches == value_q);
`endif

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    height_d = height_q;
    if (game_reset) begin
      state_d  = IDLE;
      value_d  = '0;
      height_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (spawn) begin
          // a zero target would score instantly with all switches off
          value_d  = (spawn_value == '0) ? VALUE_W'(1) : spawn_value;
          height_d = HW'(ROWS - 1);
          state_d  = FALL;
        end
        FALL: if (match_w) begin
          state_d = HIT;
        end else if (tick) begin
          if (height_q != '0) height_d = height_q - 1'b1;
          else                state_d  = OVER;
        end
        HIT:  state_d = IDLE;
        OVER: state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      value_q  <= '0;
      height_q <= '0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      height_q <= height_d;
    end
  end

  assign active    = in_fall;
  assign correct   = (state_q == HIT);
  assign game_over = (state_q == OVER);
  assign value     = value_q;
  assign height    = height_q;

endmodule
